// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM state encoding,
// default parameter values and a constant-foldable ceil(log2) helper.
package mux_rr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_N_DEF        = 4;
    localparam int ARB_WIDTH_DEF    = 16;
    localparam int ARB_MAX_HOLD_DEF = 4;

    // ceil(log2(value)); clog2(1) returns 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of i_mask searching i_last+1, i_last+2, ...
// modulo N. Rotates the mask so the search start lands on bit 0, priority
// encodes the lowest set bit, then rotates the index back. N must be 2**SEL_W
// so the index arithmetic wraps naturally.
module mux_rr_arbiter_rr_pick
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N     = ARB_N_DEF,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     i_mask,
    input  logic [SEL_W-1:0] i_last,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    logic [SEL_W-1:0] w_start;
    logic [N-1:0]     w_rot;
    logic [SEL_W-1:0] w_enc;

    assign w_start = i_last + SEL_W'(1);

    // Rotate so that bit 0 of w_rot is the requester right after i_last.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = i_mask[w_start + SEL_W'(i)];
        end
    end

    // Priority encode: lowest set bit of the rotated mask wins.
    always_comb begin
        w_enc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = SEL_W'(i);
            end
        end
    end

    assign o_idx = w_start + w_enc;
    assign o_any = |i_mask;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of an N-way word mux. Grant, select, state,
// last-served index and the burst beat counter are registered; only the
// valid flag and the muxed data word are combinational.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N        = ARB_N_DEF,
    parameter int WIDTH    = ARB_WIDTH_DEF,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic [N-1:0]             i_req,
    input  logic [N*WIDTH-1:0]       i_data_in,
    input  logic                     i_out_ready,
    output logic [N-1:0]             o_grant,
    output logic [clog2(N)-1:0]      o_sel,
    output logic                     o_out_valid,
    output logic [WIDTH-1:0]         o_out_data
);

    localparam int SEL_W = clog2(N);
    localparam int CNT_W = clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       r_state;
    logic [N-1:0]     r_grant;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_last;
    logic [CNT_W-1:0] r_beat_cnt;

    arb_state_t       w_state_nxt;
    logic [N-1:0]     w_grant_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [SEL_W-1:0] w_last_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_accept;
    logic [N-1:0]     w_others;
    logic             w_release;
    logic [N-1:0]     w_pick_mask;
    logic [SEL_W-1:0] w_pick_last;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic [N-1:0]     w_pick_onehot;

    assign o_out_valid = (r_state == ARB_BUSY) & i_req[r_sel];
    assign w_accept    = o_out_valid & i_out_ready;
    assign w_others    = i_req & ~r_grant;
    assign w_release   = ~i_req[r_sel]
                       | (w_accept & (r_beat_cnt == CNT_LAST) & (|w_others));

    // In BUSY the current holder is masked out and the search starts after it,
    // which makes a hand-over bubble-free; in IDLE the last served index is used.
    assign w_pick_mask   = (r_state == ARB_BUSY) ? w_others : i_req;
    assign w_pick_last   = (r_state == ARB_BUSY) ? r_sel    : r_last;
    assign w_pick_onehot = N'(1) << w_pick_idx;

    mux_rr_arbiter_rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .i_mask (w_pick_mask),
        .i_last (w_pick_last),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    // State register: all flops clear asynchronously; last=N-1 so requester 0 wins first.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_sel      <= '0;
            r_last     <= SEL_W'(N - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_sel      <= w_sel_nxt;
            r_last     <= w_last_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    // Next-state logic: grant on any request, release on drop or exhausted burst.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_beat_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ARB_BUSY;
                    w_grant_nxt = w_pick_onehot;
                    w_sel_nxt   = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            ARB_BUSY: begin
                if (w_release) begin
                    w_last_nxt = r_sel;
                    w_cnt_nxt  = '0;
                    if (w_pick_any) begin
                        w_grant_nxt = w_pick_onehot;
                        w_sel_nxt   = w_pick_idx;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                        w_grant_nxt = '0;
                    end
                end else if (w_accept) begin
                    // With nobody waiting the counter wraps and the grant is kept.
                    w_cnt_nxt = (r_beat_cnt == CNT_LAST) ? '0 : r_beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Output mux: word selected by the registered select.
    always_comb begin
        o_out_data = '0;
        for (int i = 0; i < N; i++) begin
            if (r_sel == SEL_W'(i)) begin
                o_out_data = i_data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign o_grant = r_grant;
    assign o_sel   = r_sel;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, rotation, solo burst, backpressure,
// early drop and reset mid-burst. Expected per-cycle outputs are queued as the
// stimulus is applied and popped when the outputs are sampled on the falling edge.
module tb_mux_rr_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 16;

    typedef struct {
        logic [N-1:0] grant;
        logic [1:0]   sel;
        logic         valid;
        logic [15:0]  data;
        int           cnt;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] data_in;
    logic               out_ready;
    logic [N-1:0]       grant;
    logic [1:0]         sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;

    int   checks;
    int   errors;
    exp_t sb_q[$];

    mux_rr_arbiter #(.N(4), .WIDTH(16), .MAX_HOLD(4)) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_req       (req),
        .i_data_in   (data_in),
        .i_out_ready (out_ready),
        .o_grant     (grant),
        .o_sel       (sel),
        .o_out_valid (out_valid),
        .o_out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] word_of(input int i);
        return 16'(32'h1357 * (i + 1));
    endfunction

    function automatic logic [1:0] idx_of(input logic [N-1:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Queue the expectation for the current cycle, compare on the falling edge,
    // then step past the next rising edge.
    task automatic cycle_check(input logic [N-1:0] g, input logic v, input int cnt);
        exp_t e;
        e.grant = g;
        e.sel   = idx_of(g);
        e.valid = v;
        e.data  = word_of(int'(idx_of(g)));
        e.cnt   = cnt;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("grant", 32'(grant), 32'(e.grant));
        chk("sel", 32'(sel), 32'(e.sel));
        chk("out_valid", 32'(out_valid), 32'(e.valid));
        if (e.valid) chk("out_data", 32'(out_data), 32'(e.data));
        if (e.cnt >= 0) chk("beat_cnt", 32'(dut.r_beat_cnt), 32'(e.cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        for (int i = 0; i < N; i++) data_in[i*WIDTH +: WIDTH] = word_of(i);
        req       = 4'b1111;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;

        // Reset held with all requests up: nothing granted.
        cycle_check(4'b0000, 1'b0, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cycle_check(4'b0000, 1'b0, 0);

        // Rotation: four beats each, no idle cycle between grants.
        for (int r = 0; r < N; r++) begin
            for (int b = 0; b < 4; b++) cycle_check(4'(1 << r), 1'b1, b);
        end
        cycle_check(4'b0001, 1'b1, 0);

        // Solo burst on requester 2: holder drops first, then 10 beats with wrap.
        req = 4'b0100;
        cycle_check(4'b0001, 1'b0, 1);
        for (int j = 0; j < 10; j++) cycle_check(4'b0100, 1'b1, j % 4);

        // Backpressure: grant to 0 held, counter frozen, then 4 beats and hand-over.
        req       = 4'b0011;
        out_ready = 1'b0;
        cycle_check(4'b0100, 1'b0, 2);
        for (int j = 0; j < 6; j++) cycle_check(4'b0001, 1'b1, 0);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) cycle_check(4'b0001, 1'b1, j);

        // Early drop: requester 1 drops after two beats, requester 3 takes over.
        req = 4'b1010;
        cycle_check(4'b0010, 1'b1, 0);
        cycle_check(4'b0010, 1'b1, 1);
        req = 4'b1000;
        cycle_check(4'b0010, 1'b0, 2);
        cycle_check(4'b1000, 1'b1, 0);

        // Reset mid-burst of requester 2.
        req = 4'b0100;
        cycle_check(4'b1000, 1'b0, 1);
        req = 4'b0101;
        cycle_check(4'b0100, 1'b1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle_check(4'b0000, 1'b0, 0);
        cycle_check(4'b0001, 1'b1, 0);
        cycle_check(4'b0001, 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
